lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store initiator between the core's memory stage and the word-only data memory (async word read, sync full-word write, no byte enables).
- Accepts byte/half/word load and store requests over a valid/ready handshake.
- Performs sign/zero extension on loads.
- Implements sub-word stores as read-modify-write.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the data memory; byte addresses at or above MEM_WORDS*4 are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size, or out-of-range.
- mem_a  out  32  word address to memory, {addr[31:2],2'b00}.
- mem_wd  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  memory read data, combinational from mem_a.

Behaviour:
- Reset (async, rst_n low): state IDLE. Outputs:
  - req_ready=1 once rst_n is high; req_ready is 0 while rst_n is low.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0.
  - All latched request registers are 0.
- mem_we is decoded from the state register only, so it falls in the same instant rst_n asserts.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at the clock edge, latch we/size/unsigned/addr/wdata and evaluate err:
    - size==11, or
    - size==01 with addr[0]=1, or
    - size==10 with addr[1:0]!=0, or
    - addr >= MEM_WORDS*4.
  - Next state:
    - err → RESP.
    - Load → RD.
    - Store word → WR.
    - Store byte/half → RD.
- RD:
  - mem_a = latched word address.
  - On the clock edge, capture mem_rd into data register.
  - Next state: load → RESP; sub-word store → WR.
- WR:
  - mem_we=1 for exactly this one cycle; mem_a = latched word address.
  - mem_wd: full wdata for word stores; for sub-word stores, captured word with the selected lane replaced:
    - byte lane = addr[1:0];
    - half lane = addr[1], bits [15:0] or [31:16].
  - Next state: RESP.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err are registered and stable while rsp_valid=1.
  - Load data extraction:
    - byte: captured[8*addr[1:0] +: 8];
    - half: captured[16*addr[1] +: 16];
    - result sign-extended unless unsigned.
  - Leave to IDLE on rsp_valid && rsp_ready.
- Latency, accept edge = cycle 0:
  - rsp_valid rises in cycle 2 for loads and word stores.
  - rsp_valid rises in cycle 3 for sub-word stores.
  - rsp_valid rises in cycle 1 for errors.
- No pipelining: one outstanding request. req_ready stays low from accept until the cycle after the response handshake.
- Err path: mem_we never asserts; mem_a keeps the latched word address.
- mem_a/mem_wd hold their last values outside RD/WR; only mem_we qualifies writes.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - A pending RMW write is dropped; memory is unchanged.
  - No response is issued for the aborted request.
- Width rules: all arithmetic is 32-bit. The range check compares the full 32-bit address; there is no wrap.

Test Plan:
- Preload word0=FACEFACE. lw addr 0x0 → rsp_valid in cycle 2, rsp_rdata=FACEFACE, rsp_err=0, mem_we never high.
- Same preload:
  - lb addr 0x0 → FFFFFFCE; lbu addr 0x0 → 000000CE.
  - lh addr 0x2 → FFFFFACE; lhu addr 0x2 → 0000FACE.
- sb addr 0x1 wdata 0x00000012 over FACEFACE → mem_we high exactly one cycle (cycle 2), mem_wd=FACE12CE, word0 reads FACE12CE afterward. sw addr 0x4 wdata 0xDEADBEEF → mem_we in cycle 1, word1=DEADBEEF.
- Error cases, each giving rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0, mem_we never high:
  - lw addr 0x3;
  - sh addr 0x5;
  - size=11;
  - sw addr 0x100 with MEM_WORDS=64.
- Backpressure: lw addr 0x8 (word2=00000003), rsp_ready held low 3 cycles → rsp_valid, rsp_rdata=00000003 and req_ready=0 all stable throughout. A req_valid pulse during this window is not accepted.
- Reset mid-RMW: sh addr 0x0 wdata 0xBEEF, drop rst_n during RD → mem_we stays 0, word0 unchanged (FACEFACE), no rsp_valid. After release, req_ready=1 and the next lw addr 0x0 returns FACEFACE.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the core's memory stage and a word-only data memory.
// Sub-word stores run as read-modify-write. Loads are sign/zero extended.
// Misaligned, illegal-size and out-of-range requests are answered with rsp_err
// and never touch memory.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// req_ready is high only in IDLE and only while rst_n is high.
// rsp_valid is high only in RESP, and rsp_rdata/rsp_err stay stable until rsp_ready is seen.
// Only one request is in flight at any time.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_t      r_state;
    state_t      w_next;

    // Request fields latched at accept.
    // Only the low half of the store data is kept, because word stores load
    // mem_wd directly at accept.
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_rsp_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_wd;

    logic        w_req_err;
    logic        w_word_store;
    logic [31:0] w_merged;
    logic [31:0] w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Classify the incoming request.
    // The range check uses the full 32-bit address, so addresses do not wrap.
    always_comb begin
        w_req_err = 1'b0;
        if (req_size == 2'b11) begin
            w_req_err = 1'b1;
        end
        if (req_size == 2'b01 && req_addr[0]) begin
            w_req_err = 1'b1;
        end
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            w_req_err = 1'b1;
        end
        if (req_addr >= ADDR_LIMIT) begin
            w_req_err = 1'b1;
        end
        w_word_store = req_we && (req_size == 2'b10);
    end

    // Next-state decode. Error requests skip memory entirely and go straight to RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = RESP;
                    end else if (w_word_store) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // State register. Asynchronous reset aborts any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Build the RMW write word: the memory word read back, with the addressed lane replaced.
    always_comb begin
        w_merged = mem_rd;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end
    end

    // Pick the addressed lane of the read word and extend it.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_size)
            2'b00:   w_load_data = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = mem_rd;
        endcase
    end

    // Datapath registers: latch the request at accept, then capture the read data in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 16'd0;
            r_rsp_err <= 1'b0;
            r_rdata   <= 32'd0;
            r_mem_wd  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_size    <= req_size;
                        r_uns     <= req_unsigned;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata[15:0];
                        r_rsp_err <= w_req_err;
                        r_rdata   <= 32'd0;
                        if (!w_req_err && w_word_store) begin
                            r_mem_wd <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (r_we) begin
                        r_mem_wd <= w_merged;
                    end else begin
                        r_rdata <= w_load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // mem_we is decoded from state only, so it drops the instant reset asserts.
    // mem_a and mem_wd are plain registered values that hold between requests.
    always_comb begin
        req_ready   = rst_n && (r_state == IDLE);
        rsp_valid   = (r_state == RESP);
        rsp_rdata   = r_rdata;
        rsp_err     = r_rsp_err;
        mem_we      = (r_state == WR);
        mem_a       = {r_addr[31:2], 2'b00};
        mem_wd      = r_mem_wd;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a word memory model, directed cases, then random requests
// checked against an arithmetic reference of the load/store rules.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    lsu_mem_ctrl #(.MEM_WORDS(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd),
        .o_dbg_state  (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Data memory: asynchronous read, synchronous write, with a preload port.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model computed from the access rules. It updates ref_mem for stores.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rdata, output int lat,
                         output int wecnt, output int wecyc, output logic [31:0] wword);
        logic [31:0] old;
        logic [31:0] v;
        int          sh;
        err   = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) ||
                (sz == 2'd2 && (addr % 4) != 0) || (addr >= 32'd256);
        rdata = 32'd0;
        wword = 32'd0;
        wecnt = 0;
        wecyc = 0;
        if (err) begin
            lat = 1;
        end else begin
            old = ref_mem[addr[7:2]];
            sh  = (sz == 2'd0) ? 8 * int'(addr % 4) : 16 * int'((addr / 2) % 2);
            if (!we) begin
                lat = 2;
                if (sz == 2'd0) begin
                    v = (old >> sh) & 32'hFF;
                    if (!uns && v[7]) v = v | 32'hFFFF_FF00;
                end else if (sz == 2'd1) begin
                    v = (old >> sh) & 32'hFFFF;
                    if (!uns && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = old;
                end
                rdata = v;
            end else begin
                wecnt = 1;
                if (sz == 2'd2) begin
                    lat   = 2;
                    wecyc = 1;
                    wword = wd;
                end else begin
                    lat   = 3;
                    wecyc = 2;
                    if (sz == 2'd0) begin
                        wword = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                    end else begin
                        wword = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                    end
                end
                ref_mem[addr[7:2]] = wword;
            end
        end
    endtask

    // Driver + monitor for one request. Starts and ends just after a falling edge.
    // hold = cycles rsp_ready is held low once the response appears.
    // pulse = drive a stray request during that window.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input logic pulse);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_wword;
        logic [31:0] q_rdata;
        logic [31:0] o_wd;
        int          e_lat, e_wecnt, e_wecyc;
        int          cyc, we_cnt, we_cyc, guard;
        logic        got;
        model(we, sz, uns, addr, wd, e_err, e_rdata, e_lat, e_wecnt, e_wecyc, e_wword);
        exp_q.push_back(e_rdata);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        rsp_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc    = 1;
        we_cnt = 0;
        we_cyc = 0;
        o_wd   = 32'd0;
        got    = 1'b0;
        while (cyc <= 8) begin
            if (mem_we) begin
                we_cnt++;
                if (we_cnt == 1) begin
                    we_cyc = cyc;
                    o_wd   = mem_wd;
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        q_rdata = exp_q.pop_front();
        check({tag, "_lat"}, got ? 32'(cyc) : 32'd99, 32'(e_lat));
        if (got) begin
            check({tag, "_rdata"}, rsp_rdata, q_rdata);
            check({tag, "_err"}, 32'(rsp_err), 32'(e_err));
            for (int h = 0; h < hold; h++) begin
                if (pulse && h == 0) begin
                    req_valid = 1'b1;
                    req_we    = 1'b1;
                    req_size  = 2'b10;
                    req_addr  = 32'h0000_000C;
                    req_wdata = $urandom;
                end
                @(negedge clk);
                req_valid = 1'b0;
                if (mem_we) we_cnt++;
                check({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, "_bp_rdata"}, rsp_rdata, q_rdata);
                check({tag, "_bp_err"}, 32'(rsp_err), 32'(e_err));
                check({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            if (mem_we) we_cnt++;
            check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
            check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
        end
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(e_wecnt));
        if (e_wecnt > 0) begin
            check({tag, "_we_cyc"}, 32'(we_cyc), 32'(e_wecyc));
            check({tag, "_wd"}, o_wd, e_wword);
        end
    endtask

    // Reset during the read phase of a half-word RMW: the write must never happen.
    task automatic reset_mid_rmw();
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b01;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_in_rd", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_we", 32'(mem_we), 32'd0);
        check("rmw_rst_ready", 32'(req_ready), 32'd0);
        check("rmw_rst_valid", 32'(rsp_valid), 32'd0);
        check("rmw_rst_state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rmw_hold_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rmw_rel_ready", 32'(req_ready), 32'd1);
            check("rmw_rel_valid", 32'(rsp_valid), 32'd0);
        end
        check("rmw_word0", mem[0], 32'hFACE_FACE);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [1:0]  r_sz;
        int          sel;
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        pl_we        = 1'b0;
        pl_idx       = 6'd0;
        pl_data      = 32'h0;

        // Preload memory while the DUT is held in reset, and check the reset outputs.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_idx  = 6'(i);
            pl_data = (i == 0) ? 32'hFACE_FACE : (i == 2) ? 32'h0000_0003 : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(req_ready), 32'd1);

        // Directed cases.
        do_req("lw0",   1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 0, 1'b0);
        do_req("lb0",   1'b0, 2'b00, 1'b0, 32'h0,   32'h0, 0, 1'b0);
        do_req("lbu0",  1'b0, 2'b00, 1'b1, 32'h0,   32'h0, 0, 1'b0);
        do_req("lh2",   1'b0, 2'b01, 1'b0, 32'h2,   32'h0, 1, 1'b0);
        do_req("lhu2",  1'b0, 2'b01, 1'b1, 32'h2,   32'h0, 0, 1'b0);
        do_req("sb1",   1'b1, 2'b00, 1'b0, 32'h1,   32'h0000_0012, 0, 1'b0);
        do_req("lw0b",  1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 0, 1'b0);
        check("word0_sb", mem[0], 32'hFACE_12CE);
        do_req("sw4",   1'b1, 2'b10, 1'b0, 32'h4,   32'hDEAD_BEEF, 0, 1'b0);
        check("word1_sw", mem[1], 32'hDEAD_BEEF);
        do_req("e_lw3", 1'b0, 2'b10, 1'b0, 32'h3,   32'h0, 0, 1'b0);
        do_req("e_sh5", 1'b1, 2'b01, 1'b0, 32'h5,   32'h1234, 0, 1'b0);
        do_req("e_sz3", 1'b0, 2'b11, 1'b0, 32'h0,   32'h0, 0, 1'b0);
        do_req("e_oor", 1'b1, 2'b10, 1'b0, 32'h100, 32'h5555_AAAA, 0, 1'b0);
        do_req("bp_lw8", 1'b0, 2'b10, 1'b0, 32'h8,  32'h0, 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_no_phantom", 32'(rsp_valid), 32'd0);
        end
        do_req("sw0",   1'b1, 2'b10, 1'b0, 32'h0,   32'hFACE_FACE, 0, 1'b0);
        reset_mid_rmw();
        do_req("lw0c",  1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 0, 1'b0);

        // Random requests, mostly legal and aligned.
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 9);
            r_sz = (sel == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            sel  = $urandom_range(0, 9);
            if (sel == 0) begin
                r_addr = 32'd256 + 32'($urandom_range(0, 64));
            end else if (sel == 1) begin
                r_addr = 32'hFFFF_FFFC - 32'($urandom_range(0, 3));
            end else begin
                r_addr = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) begin
                    if (r_sz == 2'b10) r_addr = r_addr & 32'hFC;
                    if (r_sz == 2'b01) r_addr = r_addr & 32'hFE;
                end
            end
            do_req("rnd", 1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)),
                   r_addr, $urandom, $urandom_range(0, 2), 1'b0);
        end

        // The final memory image must match the reference.
        for (int i = 0; i < 64; i++) begin
            check("mem_final", mem[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
